serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Parametrised digit-serial adder/subtractor with valid/ready handshakes on both sides.
//  Computes a+b (sel=0) or a-b (sel=1) over WIDTH bits, DIGIT bits per clock, LSB digit first.
//  Reports carry/borrow, signed overflow and zero flags.
//  Successor to the 4-bit combinational adder_cum_sub for wide operands in datapath blocks.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT   4  bits processed per clock; NDIG = WIDTH/DIGIT cycles per operation
//             DIGIT=WIDTH is legal and gives NDIG=1
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous, active-low reset
//  in_valid        in   1      operands a, b and sel are valid
//  in_ready        out  1      block can accept operands
//  a               in   WIDTH  operand A
//  b               in   WIDTH  operand B
//  sel             in   1      0 = add, 1 = subtract (a-b)
//  out_valid       out  1      result and flags are valid
//  out_ready       in   1      downstream accepts the result
//  result          out  WIDTH  sum or difference, modulo 2^WIDTH
//  cout_or_borrow  out  1      add: carry out of MSB; sub: borrow (1 iff a<b unsigned)
//  overflow        out  1      two's-complement signed overflow of the operation
//  zero            out  1      result == 0
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n): asserting it forces
//    state IDLE immediately. All registers are cleared: result=0, cout_or_borrow=0,
//    overflow=0, zero=0, out_valid=0, digit counter=0.
//  - in_ready = (state==IDLE), decoded from the state register, so in_ready=1 during and
//    after reset.
//  - FSM states and transitions:
//    IDLE -> RUN   on in_valid && in_ready; captures a, b^{WIDTH{sel}} and sel,
//                  and sets the carry register to sel.
//    RUN           each cycle adds one DIGIT slice (digit index = counter) with the carry
//                  register. Writes the slice sum into the result shift/slot and updates
//                  the carry. counter++.
//    RUN -> DONE   on the cycle that processes digit NDIG-1. On that same edge the block
//                  registers the flags:
//                  - cout_or_borrow = sel ? ~carry_out : carry_out
//                  - overflow = carry into MSB ^ carry out of MSB
//                  - zero = (final result == 0)
//                  - out_valid = 1
//    DONE -> IDLE  on out_valid && out_ready; out_valid clears on that edge.
//  - Latency: accept at edge k -> out_valid=1 after edge k+NDIG.
//    Best-case throughput is one operation per NDIG+2 cycles.
//  - No same-cycle re-accept: in_ready returns high on the cycle after the output handshake.
//  - Backpressure: while out_valid && !out_ready, result and all flags stay stable.
//    in_ready stays 0.
//  - a, b and sel are sampled only at acceptance. Changes during RUN/DONE are ignored.
//  - Output hold: result and flags keep their last values after the handshake until the
//    next operation completes. During RUN they are don't-care. Consumers qualify them with
//    out_valid.
//  - out_ready while out_valid=0 has no effect. in_valid while in_ready=0 has no effect;
//    the source must hold it.
//  - Reset mid-operation (RUN or DONE): the operation is discarded and no result is
//    produced. The block restarts in IDLE.
//  - Arithmetic is modulo 2^WIDTH; the extra carry appears only on cout_or_borrow.
// TESTING  (WIDTH=16, DIGIT=4, NDIG=4 unless noted)
//  1. add a=0x1234 b=0x0FFF -> result=0x2233, cout=0, ovf=0, zero=0.
//     out_valid rises exactly 4 edges after accept.
//  2. add a=0xFFFF b=0x0001 -> result=0x0000, cout=1, zero=1, ovf=0.
//     add a=0x7FFF b=0x0001 -> result=0x8000, cout=0, ovf=1.
//  3. sub a=0x0003 b=0x0005 -> result=0xFFFE, borrow=1, ovf=0.
//     sub a=0x8000 b=0x0001 -> result=0x7FFF, borrow=0, ovf=1.
//     sub a=b=0x5A5A -> result=0, borrow=0, zero=1.
//  4. Hold out_ready=0 for 10 cycles after out_valid -> result/flags unchanged, in_ready=0.
//     Then out_ready=1 -> out_valid drops on that edge; in_ready=1 on the next cycle.
//  5. Deassert rst_n asynchronously during RUN (2nd digit) -> out_valid=0, flags=0,
//     in_ready=1 before the next edge. The next accepted op completes correctly.
//  6. 1000 random a/b/sel back-to-back with random out_ready, at DIGIT=4, 1 and 16.
//     Every result and flag matches a {cout,sum} golden model, in order, none lost or
//     duplicated.

Source files
------------

// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, LSB digit first.
// Operands are accepted via a valid/ready handshake; the result is returned with carry/borrow, overflow and zero flags.
module serial_add_sub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout_or_borrow,
   output logic             overflow,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_valid must be held until in_ready; out_valid is held until out_ready.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
   logic             sel_q, carry_q;
   logic [CW-1:0]    cnt_q;
   logic             cout_q, ovf_q, zero_q, out_valid_q;
   logic [DIGIT-1:0] a_dig, b_dig, d_sum;
   logic             d_cout, msb_cin;
   logic             accept, release_out, last_dig;
   int unsigned      base;

   assign in_ready    = (state_q == IDLE);
   assign accept      = in_valid && in_ready;
   assign release_out = out_valid_q && out_ready;
   assign last_dig    = (cnt_q == CW'(NDIG - 1));

   assign base  = int'(cnt_q) * DIGIT;
   assign a_dig = a_q[base +: DIGIT];
   assign b_dig = b_q[base +: DIGIT];
   assign {d_cout, d_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
   // Carry into the MSB recovered from the MSB sum bit, so DIGIT=1 needs no special case.
   assign msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ d_sum[DIGIT-1];

   always_comb begin
      res_next = res_q;
      res_next[base +: DIGIT] = d_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)      state_d = RUN;
         RUN:     if (last_dig)    state_d = DONE;
         DONE:    if (release_out) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         sel_q       <= 1'b0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with sel.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sel}};
            sel_q   <= sel;
            carry_q <= sel;
            cnt_q   <= '0;
         end
         if (state_q == RUN) begin
            res_q   <= res_next;
            carry_q <= d_cout;
            cnt_q   <= cnt_q + CW'(1);
            if (last_dig) begin
               cout_q      <= sel_q ? ~d_cout : d_cout;
               ovf_q       <= msb_cin ^ d_cout;
               zero_q      <= (res_next == '0);
               out_valid_q <= 1'b1;
               cnt_q       <= '0;
            end
         end
         if (release_out) out_valid_q <= 1'b0;
      end
   end

   assign out_valid      = out_valid_q;
   assign result         = res_q;
   assign cout_or_borrow = cout_q;
   assign overflow       = ovf_q;
   assign zero           = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed cases on a DIGIT=4 instance plus randomized
// back-to-back traffic on DIGIT=4, 1 and 16 instances against an arithmetic model.
module tb_serial_add_sub;

   localparam int W  = 16;
   localparam int EW = W + 3;

   logic          clk;
   logic          rst_n;
   logic          in_valid_v [3];
   logic          in_ready_v [3];
   logic [W-1:0]  a_v        [3];
   logic [W-1:0]  b_v        [3];
   logic          sel_v      [3];
   logic          out_valid_v[3];
   logic          out_ready_v[3];
   logic [W-1:0]  result_v   [3];
   logic          cob_v      [3];
   logic          ovf_v      [3];
   logic          zero_v     [3];

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];

   genvar g;
   for (g = 0; g < 3; g++) begin : g_dut
      serial_add_sub #(
         .WIDTH(W),
         .DIGIT((g == 0) ? 4 : ((g == 1) ? 1 : 16))
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .in_valid      (in_valid_v[g]),
         .in_ready      (in_ready_v[g]),
         .a             (a_v[g]),
         .b             (b_v[g]),
         .sel           (sel_v[g]),
         .out_valid     (out_valid_v[g]),
         .out_ready     (out_ready_v[g]),
         .result        (result_v[g]),
         .cout_or_borrow(cob_v[g]),
         .overflow      (ovf_v[g]),
         .zero          (zero_v[g])
      );
   end

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {zero, overflow, carry_or_borrow, result} from plain integer arithmetic.
   function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
      logic [W:0] full;
      int         sr;
      if (s) begin
         full = {1'b0, x} - {1'b0, y};
         sr   = int'($signed(x)) - int'($signed(y));
      end else begin
         full = {1'b0, x} + {1'b0, y};
         sr   = int'($signed(x)) + int'($signed(y));
      end
      return {full[W-1:0] == '0, (sr > 32767) || (sr < -32768), full[W], full[W-1:0]};
   endfunction

   function automatic logic [EW-1:0] obs(input int k);
      return {zero_v[k], ovf_v[k], cob_v[k], result_v[k]};
   endfunction

   // driver tasks (instance 0); entered and left at posedge+1
   task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output int lat);
      int w;
      a_v[0] = x; b_v[0] = y; sel_v[0] = s; in_valid_v[0] = 1'b1;
      w = 0;
      while (!in_ready_v[0] && w < 50) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      a_v[0] = W'($urandom); b_v[0] = W'($urandom); sel_v[0] = 1'($urandom);
      lat = 0;
      while (!out_valid_v[0] && lat < 50) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic take;
      out_ready_v[0] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[0] = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      total++;
      if (in_ready_v[0] !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_v[0]);
      end
      total++;
      if (out_valid_v[0] !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_v[0]);
      end
      total++;
      if (obs(0) !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", obs(0));
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({in_ready_v[0], out_valid_v[0]} !== 2'b10) begin
         bad++; $display("FAIL post_reset_hs: got %b want 10", {in_ready_v[0], out_valid_v[0]});
      end
   endtask

   task automatic run_table(input string name, input logic [W-1:0] ta[3],
                            input logic [W-1:0] tb[3], input logic ts,
                            input logic [EW-1:0] te[3], input int n);
      int lat;
      for (int i = 0; i < n; i++) begin
         send_op(ta[i], tb[i], ts, lat);
         total++;
         if (lat !== 4) begin
            bad++; $display("FAIL %s_latency[%0d]: got %0d want 4", name, i, lat);
         end
         total++;
         if (obs(0) !== te[i]) begin
            bad++; $display("FAIL %s_value[%0d]: got %h want %h", name, i, obs(0), te[i]);
         end
         take();
      end
   endtask

   task automatic test_add;
      logic [W-1:0]  ta[3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
      logic [W-1:0]  tb[3] = '{16'h0FFF, 16'h0001, 16'h0001};
      logic [EW-1:0] te[3] = '{19'h02233, 19'h50000, 19'h28000};
      run_table("add", ta, tb, 1'b0, te, 3);
   endtask

   task automatic test_sub;
      logic [W-1:0]  ta[3] = '{16'h0003, 16'h8000, 16'h5A5A};
      logic [W-1:0]  tb[3] = '{16'h0005, 16'h0001, 16'h5A5A};
      logic [EW-1:0] te[3] = '{19'h1FFFE, 19'h27FFF, 19'h40000};
      run_table("sub", ta, tb, 1'b1, te, 3);
   endtask

   task automatic test_backpressure;
      int            lat;
      logic [EW-1:0] e;
      e = 19'h0FFFF;
      send_op(16'hA5A5, 16'h5A5A, 1'b0, lat);
      total++;
      if (lat !== 4) begin
         bad++; $display("FAIL bp_latency: got %0d want 4", lat);
      end
      for (int i = 0; i < 10; i++) begin
         total++;
         if ({out_valid_v[0], in_ready_v[0], obs(0)} !== {2'b10, e}) begin
            bad++;
            $display("FAIL bp_hold[%0d]: got %h want %h", i,
                     {out_valid_v[0], in_ready_v[0], obs(0)}, {2'b10, e});
         end
         @(posedge clk); #1;
      end
      take();
      total++;
      if ({out_valid_v[0], in_ready_v[0], obs(0)} !== {2'b01, e}) begin
         bad++;
         $display("FAIL bp_release: got %h want %h",
                  {out_valid_v[0], in_ready_v[0], obs(0)}, {2'b01, e});
      end
   endtask

   task automatic test_reset_mid;
      int   lat;
      logic seen;
      a_v[0] = 16'h1111; b_v[0] = 16'h2222; sel_v[0] = 1'b0; in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid_v[0], in_ready_v[0], obs(0)} !== {2'b01, {EW{1'b0}}}) begin
         bad++;
         $display("FAIL reset_mid: got %h want %h",
                  {out_valid_v[0], in_ready_v[0], obs(0)}, {2'b01, {EW{1'b0}}});
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid_v[0]) seen = 1'b1;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL reset_mid_discard: got out_valid=%b want 0", seen);
      end
      send_op(16'h1234, 16'h4321, 1'b1, lat);
      total++;
      if ({lat[3:0], obs(0)} !== {4'd4, 19'h1CF13}) begin
         bad++; $display("FAIL reset_mid_next: got lat=%0d %h want lat=4 %h", lat, obs(0),
                         19'h1CF13);
      end
      take();
   endtask

   task automatic run_random(input int k, input int nops, input int budget);
      int            sent, got, cyc;
      logic          accepted;
      logic [EW-1:0] e;
      sent = 0; got = 0; cyc = 0;
      exp_q.delete();
      while (got < nops && cyc < budget) begin
         if (!in_valid_v[k] && sent < nops && $urandom_range(0, 3) != 0) begin
            a_v[k] = W'($urandom); b_v[k] = W'($urandom); sel_v[k] = 1'($urandom);
            in_valid_v[k] = 1'b1;
         end
         out_ready_v[k] = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         accepted = in_valid_v[k] && in_ready_v[k];
         if (accepted) begin
            exp_q.push_back(model(a_v[k], b_v[k], sel_v[k]));
            sent++;
         end
         if (out_valid_v[k] && out_ready_v[k]) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL rand%0d_extra: got %h want nothing", k, obs(k));
            end else begin
               e = exp_q.pop_front();
               if (obs(k) !== e) begin
                  bad++; $display("FAIL rand%0d_op%0d: got %h want %h", k, got, obs(k), e);
               end
            end
            got++;
         end
         @(posedge clk); #1;
         if (accepted) in_valid_v[k] = 1'b0;
         cyc++;
      end
      out_ready_v[k] = 1'b0;
      in_valid_v[k]  = 1'b0;
      total++;
      if (got != nops || exp_q.size() != 0) begin
         bad++; $display("FAIL rand%0d_count: got %0d results (%0d pending) want %0d", k, got,
                         exp_q.size(), nops);
      end
   endtask

   task automatic test_back_to_back;
      run_random(0, 1000, 12000);
      run_random(1, 1000, 26000);
      run_random(2, 1000, 8000);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         in_valid_v[i]  = 1'b0;
         out_ready_v[i] = 1'b0;
         a_v[i]         = '0;
         b_v[i]         = '0;
         sel_v[i]       = 1'b0;
      end
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
